// File: rtl/led_pattern_sched.sv
// led_pattern_sched: DIP-selected knight-rider sweep / triple blink sequencer for a 4-LED bank,
// with pattern changes only at sequence boundaries and push-buttons OR-ed over the output.
module led_pattern_sched #(
  parameter int STEP_CYCLES  = 5000000,
  parameter int BLINK_CYCLES = 8000000,
  parameter int SEQ_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       dip_i,
  input  logic [3:0]       p_i,
  output logic [3:0]       led_o,
  output logic [1:0]       mode_o,
  output logic             seq_done_o,
  output logic [SEQ_W-1:0] seq_count_o
);
  localparam int MAX_CYC = STEP_CYCLES > BLINK_CYCLES ? STEP_CYCLES : BLINK_CYCLES;
  localparam int PW = MAX_CYC > 1 ? $clog2(MAX_CYC) : 1;
  localparam logic [PW-1:0] STEP_LAST  = PW'(STEP_CYCLES - 1);
  localparam logic [PW-1:0] BLINK_LAST = PW'(BLINK_CYCLES - 1);
  localparam logic [7:0][3:0] SWEEP_PAT = {4'b0000, 4'b0001, 4'b0010, 4'b0100,
                                           4'b1000, 4'b0100, 4'b0010, 4'b0001};
  typedef enum logic [1:0] {IDLE = 2'b00, SWEEP = 2'b01, BLINK = 2'b10} state_t;
  state_t           state_q, state_d, target;
  logic [3:0]       dip_m_q, dip_s_q, p_m_q, p_s_q, led_q, pat;
  logic [PW-1:0]    presc_q, presc_d;
  logic [2:0]       step_q, step_d;
  logic [SEQ_W-1:0] cnt_q;
  logic             term, seq_end, reload;
  assign target  = dip_s_q == 4'b1001 ? SWEEP : dip_s_q == 4'b0000 ? IDLE : BLINK;
  assign term    = presc_q == (state_q == SWEEP ? STEP_LAST : BLINK_LAST);
  assign seq_end = state_q != IDLE && term && step_q == (state_q == SWEEP ? 3'd7 : 3'd5);
  // The decode is only sampled in IDLE or at a sequence end, so a pattern is never cut short.
  assign reload  = state_q == IDLE || seq_end;
  assign pat     = state_q == SWEEP ? SWEEP_PAT[step_q] :
                   state_q == BLINK && !step_q[0] ? 4'b1111 : 4'b0000;
  always_comb begin
    state_d = state_q;
    presc_d = term ? '0 : presc_q + 1'b1;
    step_d  = term ? step_q + 3'd1 : step_q;
    state_d = reload ? target : state_d;
    presc_d = reload ? '0 : presc_d;
    step_d  = reload ? '0 : step_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dip_m_q <= '0;
      dip_s_q <= '0;
      p_m_q   <= '0;
      p_s_q   <= '0;
      state_q <= IDLE;
      presc_q <= '0;
      step_q  <= '0;
      led_q   <= '0;
      cnt_q   <= '0;
    end else begin
      dip_m_q <= dip_i;
      dip_s_q <= dip_m_q;
      p_m_q   <= p_i;
      p_s_q   <= p_m_q;
      state_q <= state_d;
      presc_q <= presc_d;
      step_q  <= step_d;
      led_q   <= pat | p_s_q;
      cnt_q   <= cnt_q + SEQ_W'(seq_end);
    end
  end
  assign led_o       = led_q;
  assign mode_o      = state_q;
  assign seq_done_o  = seq_end;
  assign seq_count_o = cnt_q;
endmodule

// File: tb/tb_led_pattern_sched.sv
// tb_led_pattern_sched: stimulus pushes time-stamped expected outputs; a negedge monitor pops and compares.
module tb_led_pattern_sched;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] dip, p, led;
  logic [1:0] mode;
  logic       done;
  logic [7:0] cnt;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct {int t; int k; int v;} exp_t;
  exp_t sb[$];
  logic [3:0] sw [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000};
  string names [4] = '{"led", "mode", "seq_done", "seq_count"};

  led_pattern_sched #(.STEP_CYCLES(4), .BLINK_CYCLES(3), .SEQ_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .dip_i(dip), .p_i(p),
    .led_o(led), .mode_o(mode), .seq_done_o(done), .seq_count_o(cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(string n, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", n, cyc, act, req);
    end
  endtask

  function automatic int actual(int k);
    return k == 0 ? int'(led) : k == 1 ? int'(mode) : k == 2 ? int'(done) : int'(cnt);
  endfunction

  always @(negedge clk)
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].t <= cyc) begin
        if (sb[i].t < cyc) begin
          checks++;
          errors++;
          $display("FAIL %s expectation for cycle %0d never sampled (now %0d)", names[sb[i].k], sb[i].t, cyc);
        end else
          check(names[sb[i].k], actual(sb[i].k), sb[i].v);
        sb.delete(i);
      end

  task automatic push(int t, int k, int v);
    sb.push_back('{t, k, v});
  endtask

  task automatic push_all(int t, int l, int m, int d, int c);
    push(t, 0, l); push(t, 1, m); push(t, 2, d); push(t, 3, c);
  endtask

  task automatic push_sweep(int s, int n);
    for (int st = 0; st < n; st++)
      for (int j = 1; j <= 4; j++) push(s + 4 * st + j, 0, int'(sw[st]));
  endtask

  task automatic push_blink(int s, int ov, int from, int to);
    for (int j = 1; j <= 18; j++) begin
      int t = s + j;
      push(t, 0, ((((j - 1) / 3) % 2) == 1 ? 0 : 15) | ((t >= from && t <= to) ? ov : 0));
    end
  endtask

  task automatic wait_until(int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    int s1, s2, s3, s4, s5, s6;
    rst_n = 1'b0; dip = 4'b1001; p = 4'b1111;
    for (int t = 1; t <= 4; t++) push_all(t, 0, 0, 0, 0);
    wait_until(5);
    rst_n = 1'b1; dip = 4'b0000; p = 4'b0000;
    for (int t = 6; t <= 9; t++) begin push(t, 0, 0); push(t, 1, 0); end
    // full sweep from IDLE, then a second back-to-back sweep
    wait_until(10);
    dip = 4'b1001;
    s1 = 13; s2 = s1 + 32;
    push(s1 - 1, 1, 0); push(s1, 1, 1);
    push_sweep(s1, 8);
    push(s1 + 16, 2, 0); push(s1 + 30, 2, 0); push(s1 + 31, 2, 1); push(s1 + 32, 2, 0);
    push(s1 + 31, 3, 0); push(s1 + 32, 3, 1);
    push(s2, 1, 1);
    push_sweep(s2, 8);
    push(s2 + 31, 2, 1); push(s2 + 32, 3, 2);
    // dip change at step 2 of the second sweep waits for its end
    wait_until(s2 + 8);
    dip = 4'b0011;
    s3 = s2 + 32; s4 = s3 + 18;
    push(s2 + 20, 1, 1); push(s3 - 1, 1, 1); push(s3, 1, 2);
    push_blink(s3, 4, s3 + 6, s3 + 15);
    push(s3 + 17, 3, 2); push(s3 + 17, 2, 1); push(s3 + 18, 3, 3); push(s3 + 18, 1, 2);
    wait_until(s3 + 3);
    p = 4'b0100;
    wait_until(s3 + 13);
    p = 4'b0000;
    push_blink(s4, 0, 0, -1);
    wait_until(s4 + 3);
    dip = 4'b0000;
    push(s4 + 17, 1, 2); push(s4 + 17, 2, 1); push(s4 + 18, 1, 0); push(s4 + 18, 3, 4);
    for (int t = s4 + 19; t <= s4 + 21; t++) begin push(t, 0, 0); push(t, 1, 0); end
    // reset in the middle of a sweep
    wait_until(s4 + 22);
    dip = 4'b1001;
    s5 = s4 + 25;
    push(s5, 1, 1);
    push_sweep(s5, 5);
    push(s5 + 21, 0, 2);
    push_all(s5 + 22, 0, 0, 0, 0); push_all(s5 + 23, 0, 0, 0, 0);
    wait_until(s5 + 21);
    rst_n = 1'b0;
    #1;
    check("async_led", int'(led), 0);
    check("async_mode", int'(mode), 0);
    check("async_count", int'(cnt), 0);
    check("async_done", int'(done), 0);
    wait_until(s5 + 23);
    rst_n = 1'b1;
    s6 = s5 + 26;
    push(s6 - 2, 1, 0); push(s6 - 1, 1, 0); push(s6, 1, 1);
    push(s6 - 1, 0, 0); push(s6, 0, 0);
    push_sweep(s6, 8);
    push(s6 + 31, 2, 1); push(s6 + 31, 3, 0); push(s6 + 32, 3, 1);
    push(s6 + 32 * 255, 3, 255);
    push(s6 + 32 * 256 - 1, 3, 255); push(s6 + 32 * 256 - 1, 2, 1);
    push(s6 + 32 * 256, 3, 0); push(s6 + 32 * 256, 1, 1); push(s6 + 32 * 256, 2, 0);
    wait_until(s6 + 32 * 256 + 8);
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
